text_banner_ctrl: RTL

//   Sequences a row of N_GLYPH character renderers (26x40 glyph boxes) as an animated text banner.

---
 rtl/text_banner_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/text_banner_ctrl.sv
// Animated text banner sequencer: slides a row of glyphs in and out and merges their pixel returns.
// Optional blink of the resting banner is enabled by defining BLINK_EN.
module text_banner_ctrl #(
  parameter int N_GLYPH      = 4,
  parameter int PITCH        = 32,
  parameter int BASE_X       = 256,
  parameter int TARGET_Y     = 200,
  parameter int HIDE_Y       = 480,
  parameter int STEP         = 8,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic                   show_req,
  input  logic                   hide_req,
  input  logic [N_GLYPH-1:0]     glyph_hit,
  output logic [10*N_GLYPH-1:0]  glyph_x,
  output logic [9:0]             start_y,
  output logic                   pixel_on,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {HIDDEN, SLIDE_IN, SHOWN, SLIDE_OUT} state_e;

  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [10:0] TGT11  = 11'(TARGET_Y);
  localparam logic [10:0] HIDE11 = 11'(HIDE_Y);

  state_e      state_q, req_state;
  logic [9:0]  y_q;
  logic [10:0] y_ext, y_dn, y_up;
  logic        pixel_on_q, done_q, visible, stay_shown;

  for (genvar i = 0; i < N_GLYPH; i++) begin : g_x
    assign glyph_x[10*i +: 10] = 10'(BASE_X + i*PITCH);
  end

  // Request handling before movement; hide wins over show.
  always_comb begin
    req_state = state_q;
    case (state_q)
      HIDDEN:    if (show_req && !hide_req) req_state = SLIDE_IN;
      SLIDE_IN:  if (hide_req)              req_state = SLIDE_OUT;
      SHOWN:     if (hide_req)              req_state = SLIDE_OUT;
      SLIDE_OUT: if (show_req && !hide_req) req_state = SLIDE_IN;
      default:                              req_state = HIDDEN;
    endcase
  end

  // 11-bit clamped motion so start_y never overshoots either end.
  assign y_ext      = {1'b0, y_q};
  assign y_dn       = (y_ext >= TGT11 + STEP11) ? y_ext - STEP11 : TGT11;
  assign y_up       = (y_ext + STEP11 <= HIDE11) ? y_ext + STEP11 : HIDE11;
  assign stay_shown = (state_q == SHOWN) && (req_state == SHOWN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HIDDEN;
      y_q     <= HIDE11[9:0];
      done_q  <= 1'b0;
    end else begin
      state_q <= req_state;
      done_q  <= 1'b0;
      if (frame_tick) begin
        if (req_state == SLIDE_IN) begin
          y_q <= y_dn[9:0];
          if (y_dn == TGT11) begin
            state_q <= SHOWN;
            done_q  <= 1'b1;
          end
        end else if (req_state == SLIDE_OUT) begin
          y_q <= y_up[9:0];
          if (y_up == HIDE11) begin
            state_q <= HIDDEN;
            done_q  <= 1'b1;
          end
        end
      end
    end
  end

`ifdef BLINK_EN
  localparam int CW = $clog2(BLINK_FRAMES + 1);
  localparam logic [CW-1:0] BF = CW'(BLINK_FRAMES);

  logic [CW-1:0] blink_cnt_q;
  logic          phase_q;

  // Phase only runs while resting on screen; any other state restarts it lit.
  always_ff @(posedge clk) begin
    if (reset || !stay_shown) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt_q + 1'b1 == BF) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end
  assign visible = phase_q;
`else
  logic unused_blink;
  assign unused_blink = stay_shown;
  assign visible      = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) pixel_on_q <= 1'b0;
    else       pixel_on_q <= (|glyph_hit) && (state_q != HIDDEN) && visible;
  end

  assign start_y  = y_q;
  assign pixel_on = pixel_on_q;
  assign done     = done_q;
  assign busy     = (state_q == SLIDE_IN) || (state_q == SLIDE_OUT);

endmodule
